// File: rtl/parking_occupancy_fsm_if.sv
// parking_occupancy_fsm_if: sensor inputs and occupancy/gate outputs of the parking controller
interface parking_occupancy_fsm_if;
    logic       enter_sensor;
    logic       exit_sensor;
    logic [3:0] fsm_state;
    logic       full;
    logic       empty;
    logic       gate_open;
    logic       enter_reject;
    logic       exit_error;
    modport master (
        output enter_sensor, exit_sensor,
        input  fsm_state, full, empty, gate_open, enter_reject, exit_error
    );
    modport slave (
        input  enter_sensor, exit_sensor,
        output fsm_state, full, empty, gate_open, enter_reject, exit_error
    );
endinterface

// File: rtl/parking_occupancy_fsm.sv
// parking_occupancy_fsm: debounced entry/exit counting with saturating occupancy and a timed gate
module parking_occupancy_fsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    parking_occupancy_fsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT} state_t;
    logic [1:0]  w_raw;
    logic [1:0]  w_evt;
    logic        w_ent;
    logic        w_ext;
    logic        w_inc;
    logic        w_dec;
    logic        w_rej;
    logic        w_err;
    logic [3:0]  w_count_nxt;
    logic [15:0] w_timer_nxt;
    state_t      w_state_nxt;
    state_t      r_state;
    logic [15:0] r_timer;
    logic [3:0]  r_count;
    logic        r_full;
    logic        r_empty;
    logic        r_gate_open;
    logic        r_rej;
    logic        r_err;
    assign w_raw = {bus.exit_sensor, bus.enter_sensor};
    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic       r_s1;
        logic       r_s2;
        logic       r_filt;
        logic       r_filt_d;
        logic [7:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_filt   <= 1'b0;
                r_filt_d <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1     <= w_raw[i];
                r_s2     <= r_s1;
                r_filt_d <= r_filt;
                if (r_s2 == r_filt) r_cnt <= '0;
                else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt <= r_s2;
                    r_cnt  <= '0;
                end else r_cnt <= r_cnt + 8'd1;
            end
        end
        assign w_evt[i] = r_filt & ~r_filt_d;
    end
    assign w_ent       = w_evt[0];
    assign w_ext       = w_evt[1];
    assign w_inc       = w_ent & ~w_ext & (r_count != 4'd15);
    assign w_dec       = w_ext & ~w_ent & (r_count != 4'd0);
    assign w_rej       = w_ent & ~w_ext & (r_count == 4'd15);
    assign w_err       = w_ext & ~w_ent & (r_count == 4'd0);
    assign w_count_nxt = w_inc ? r_count + 4'd1 : w_dec ? r_count - 4'd1 : r_count;
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        if (r_state == IDLE) w_state_nxt = (w_inc || (w_ent && w_ext)) ? OPEN_IN : w_dec ? OPEN_OUT : IDLE;
        else if (r_timer == 16'(GATE_CYCLES - 1)) w_state_nxt = IDLE;
        else w_timer_nxt = r_timer + 16'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_gate_open <= 1'b0;
            r_rej       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_count_nxt == 4'd15;
            r_empty     <= w_count_nxt == 4'd0;
            r_gate_open <= w_state_nxt != IDLE;
            r_rej       <= w_rej;
            r_err       <= w_err;
        end
    end
    assign bus.fsm_state    = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.gate_open    = r_gate_open;
    assign bus.enter_reject = r_rej;
    assign bus.exit_error   = r_err;
endmodule

// File: tb/tb_parking_occupancy_fsm.sv
// tb_parking_occupancy_fsm: scoreboard bench for the parking occupancy controller
module tb_parking_occupancy_fsm;
    localparam int D = 4;
    localparam int G = 16;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   q_state[$];
    int   q_gate[$];
    int   q_rej[$];
    int   q_err[$];
    parking_occupancy_fsm_if bus ();
    parking_occupancy_fsm #(.DEBOUNCE_CYCLES(D), .GATE_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic drive_pulse(input bit ent, input bit ext, input int hi, input int lo);
        @(negedge clk);
        bus.enter_sensor = ent;
        bus.exit_sensor  = ext;
        repeat (hi) @(negedge clk);
        bus.enter_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        repeat (lo) @(negedge clk);
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask
    task automatic check_drain(input string tag);
        check({tag, "_state_left"}, q_state.size(), 0);
        check({tag, "_gate_left"}, q_gate.size(), 0);
        check({tag, "_rej_left"}, q_rej.size(), 0);
        check({tag, "_err_left"}, q_err.size(), 0);
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, bus.fsm_state, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_gate"}, bus.gate_open, 0);
        check({tag, "_rej"}, bus.enter_reject, 0);
        check({tag, "_err"}, bus.exit_error, 0);
    endtask
    always @(negedge clk) begin : mon
        int       e;
        int       gate_len;
        logic     prev_rej;
        logic     prev_err;
        logic [3:0] prev_state;
        if (!rst_n) begin
            prev_state = bus.fsm_state;
            gate_len   = 0;
            prev_rej   = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (bus.fsm_state != prev_state) begin
                if (q_state.size() == 0) check("state_unexpected", bus.fsm_state, prev_state);
                else begin
                    e = q_state.pop_front();
                    check("state", bus.fsm_state, e);
                    check("full", bus.full, int'(e == 15));
                    check("empty", bus.empty, int'(e == 0));
                end
                prev_state = bus.fsm_state;
            end
            if (prev_rej) check("rej_width", bus.enter_reject, 0);
            else if (bus.enter_reject) begin
                if (q_rej.size() == 0) check("rej_unexpected", 1, 0);
                else begin
                    e = q_rej.pop_front();
                    check("rej_at_count", bus.fsm_state, e);
                end
            end
            if (prev_err) check("err_width", bus.exit_error, 0);
            else if (bus.exit_error) begin
                if (q_err.size() == 0) check("err_unexpected", 1, 0);
                else begin
                    e = q_err.pop_front();
                    check("err_at_count", bus.fsm_state, e);
                end
            end
            prev_rej = bus.enter_reject;
            prev_err = bus.exit_error;
            if (bus.gate_open) gate_len++;
            else if (gate_len > 0) begin
                if (q_gate.size() == 0) check("gate_unexpected", gate_len, 0);
                else begin
                    e = q_gate.pop_front();
                    check("gate_len", gate_len, e);
                end
                gate_len = 0;
            end
        end
    end
    initial begin
        int lat;
        int seen;
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b0;
        bus.enter_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        #2 rst_n = 1'b1;
        q_state.push_back(1);
        q_gate.push_back(G);
        @(negedge clk);
        bus.enter_sensor = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.fsm_state == 4'd1) begin
                lat = n;
                break;
            end
        end
        check("entry_latency", lat, D + 3);
        repeat (13) @(negedge clk);
        bus.enter_sensor = 1'b0;
        repeat (20) @(negedge clk);
        check_drain("single");
        drive_pulse(1'b1, 1'b0, 3, 20);
        check("glitch_state", bus.fsm_state, 1);
        check_drain("glitch");
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            q_state.push_back(k);
            q_gate.push_back(G);
            drive_pulse(1'b1, 1'b0, 8, 18);
        end
        q_rej.push_back(15);
        drive_pulse(1'b1, 1'b0, 8, 24);
        check("full_state", bus.fsm_state, 15);
        check("full_flag", bus.full, 1);
        check_drain("full_lot");
        q_gate.push_back(G);
        drive_pulse(1'b1, 1'b1, 8, 24);
        check("simul_state", bus.fsm_state, 15);
        check_drain("simul");
        do_reset();
        q_err.push_back(0);
        drive_pulse(1'b0, 1'b1, 8, 20);
        check("empty_exit_state", bus.fsm_state, 0);
        check("empty_exit_flag", bus.empty, 1);
        check_drain("empty_exit");
        for (int k = 1; k <= 6; k++) begin
            q_state.push_back(k);
            q_gate.push_back(G);
            drive_pulse(1'b1, 1'b0, 8, 18);
        end
        q_state.push_back(7);
        @(negedge clk);
        bus.enter_sensor = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.gate_open) begin
                seen = 1;
                break;
            end
        end
        check("midrst_gate_seen", seen, 1);
        bus.enter_sensor = 1'b0;
        check("midrst_count", bus.fsm_state, 7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_state", bus.fsm_state, 0);
        check("post_rst_gate", bus.gate_open, 0);
        check_drain("midrst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.enter_sensor = 1'b1;
        repeat (2) @(negedge clk);
        q_state.push_back(1);
        q_gate.push_back(G);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        bus.enter_sensor = 1'b0;
        repeat (20) @(negedge clk);
        check("held_state", bus.fsm_state, 1);
        check_drain("held");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/parking_occupancy_fsm.md
PARKING_OCCUPANCY_FSM -- requirements
Module: parking_occupancy_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a sensor level change (legal range 1..255).
- GATE_CYCLES, 16, cycles gate_open is held per accepted event (legal range 1..65535).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, async active-low reset.
- enter_sensor, in, 1, raw asynchronous entry-lane sensor, high = vehicle present.
- exit_sensor, in, 1, raw asynchronous exit-lane sensor, high = vehicle present.
- fsm_state, out, 4, registered occupancy count 0..15; 15 = lot full.
- full, out, 1, registered; high when fsm_state == 15.
- empty, out, 1, registered; high when fsm_state == 0.
- gate_open, out, 1, registered; barrier open command.
- enter_reject, out, 1, one-cycle pulse; entry attempted while full.
- exit_error, out, 1, one-cycle pulse; exit detected while empty.

Function
REQ-004 Each raw sensor SHALL pass through a two-flop synchronizer before any other use.
REQ-005 Each synchronized sensor SHALL be debounced: the filtered level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clocks; any agreeing cycle SHALL clear the mismatch counter.
REQ-006 An entry or exit event SHALL be a single-cycle rising edge of the corresponding filtered level; falling edges SHALL produce no event.
REQ-007 Entry event only, count < 15: count SHALL increment by 1.
REQ-008 Entry event only, count == 15: count SHALL be unchanged and enter_reject SHALL pulse for exactly one cycle.
REQ-009 Exit event only, count > 0: count SHALL decrement by 1.
REQ-010 Exit event only, count == 0: count SHALL be unchanged and exit_error SHALL pulse for exactly one cycle.
REQ-011 Entry and exit events in the same cycle SHALL leave count unchanged, with no reject or error pulse, at every count value including 0 and 15.
REQ-012 The count SHALL never wrap; it SHALL saturate at 0 and 15.
REQ-013 fsm_state, full and empty SHALL update in the same clock edge.
REQ-014 fsm_state SHALL change exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the raw sensor at its new level, given the input is held stable.
REQ-015 enter_reject and exit_error SHALL assert on the same edge on which count would have changed.
REQ-016 The gate FSM SHALL have the states IDLE, OPEN_IN and OPEN_OUT:
- IDLE -> OPEN_IN on an accepted entry (REQ-007).
- IDLE -> OPEN_OUT on an accepted exit (REQ-009).
- Simultaneous events (REQ-011) in IDLE -> OPEN_IN.
- OPEN_IN or OPEN_OUT -> IDLE after GATE_CYCLES cycles.
REQ-017 gate_open SHALL be high exactly while the FSM is in OPEN_IN or OPEN_OUT, for exactly GATE_CYCLES cycles, starting the edge after the accepting event.
REQ-018 Events arriving while the gate is open SHALL still update the count, but SHALL NOT restart or extend the gate timer.
REQ-019 Rejected or errored events SHALL NOT open the gate.

Reset
REQ-020 Asserting rst_n low SHALL immediately clear the following, regardless of clock:
- count and fsm_state to 0, full to 0, empty to 1.
- gate_open, enter_reject and exit_error to 0.
- synchronizers, filtered levels and debounce counters to 0.
- gate FSM to IDLE and gate timer to 0.
REQ-021 Reset asserted mid-debounce or mid-gate-open SHALL abort that activity.
REQ-022 After reset release, a sensor already held high SHALL produce exactly one event, DEBOUNCE_CYCLES+3 edges later.

Verification
REQ-023 The bench SHALL cover these directed scenarios (DEBOUNCE_CYCLES=4, GATE_CYCLES=16):
- Single entry: enter_sensor held high 20 cycles from reset → fsm_state 0→1 seven edges after first sample; gate_open high exactly 16 cycles; empty 1→0.
- Glitch rejection: enter_sensor high 3 cycles, then low → no fsm_state change, gate_open stays 0.
- Full lot: 15 entries, then a 16th → fsm_state 15, full=1; one enter_reject pulse; fsm_state stays 15; no gate opening.
- Empty exit: exit event at count 0 → one exit_error pulse; fsm_state stays 0, empty=1.
- Simultaneous: both sensors rise in the same cycle at count 15 → count stays 15, no reject pulse, gate_open via OPEN_IN for 16 cycles.
- Mid-operation reset: rst_n low during gate open at count 7 → all outputs at reset values immediately; no event after release while sensors are low.
